// File: rtl/dp_be_ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller sequencing one dual-port byte-enable RAM.
// Latency: a push into an empty FIFO shows up on m_valid/m_data two edges after acceptance.
// Backpressure: s_ready drops when the RAM holds D words; m_ready low holds the head stable.
module dp_be_ram_fifo_ctrl #(
  parameter  int W  = 256,
  parameter  int D  = 64,
  localparam int AW = $clog2(D),
  localparam int BW = W / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W-1:0]    s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [W-1:0]    m_data,
  output logic [AW+1:0]   count,
  output logic            empty,
  output logic            full,
  output logic            ram_ena,
  output logic [AW-1:0]   ram_addra,
  output logic [BW-1:0]   ram_wea,
  output logic [W-1:0]    ram_dina,
  output logic            ram_enb,
  output logic [AW-1:0]   ram_addrb,
  output logic [BW-1:0]   ram_web,
  output logic [W-1:0]    ram_dinb,
  input  logic [W-1:0]    ram_doutb
);

  localparam logic [AW:0] DEPTH = (AW+1)'(D);

  // Pointers carry one extra wrap bit so that full and empty are distinguishable.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          rif_q, rif_d;
  logic [W-1:0]  ob_q [2];
  logic [W-1:0]  ob_d [2];
  logic [1:0]    ob_cnt_q, ob_cnt_d;

  logic [AW:0]   ram_cnt;
  logic          push;
  logic          pop;
  logic          rd_en;
  logic [2:0]    occ;

  assign ram_cnt = wr_ptr_q - rd_ptr_q;

  // s_ready depends on registered state only, never on s_valid or m_ready.
  assign s_ready = rst_n & (ram_cnt != DEPTH);
  assign push    = s_valid & s_ready;
  assign m_valid = (ob_cnt_q != 2'd0);
  assign pop     = rst_n & m_valid & m_ready;
  assign m_data  = ob_q[0];

  // Words already in the buffer plus the one arriving from RAM; a read is only
  // issued when its result is guaranteed a free buffer slot after this edge.
  assign occ   = {1'b0, ob_cnt_q} + {2'b00, rif_q};
  assign rd_en = rst_n & (ram_cnt != '0) & (occ < (3'd2 + {2'b00, pop}));

  assign ram_ena   = push;
  assign ram_addra = wr_ptr_q[AW-1:0];
  assign ram_wea   = push ? {BW{1'b1}} : {BW{1'b0}};
  assign ram_dina  = s_data;
  assign ram_enb   = rd_en;
  assign ram_addrb = rd_ptr_q[AW-1:0];
  assign ram_web   = '0;
  assign ram_dinb  = '0;

  assign count = {1'b0, ram_cnt} + {{(AW+1){1'b0}}, rif_q} + {{AW{1'b0}}, ob_cnt_q};
  assign empty = (count == '0);
  assign full  = (ram_cnt == DEPTH);

  // Next-state: pointer advance, read-in-flight flag, and output buffer pop/append.
  always_comb begin
    logic [1:0] base;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rif_d    = rd_en;
    ob_d     = ob_q;
    ob_cnt_d = ob_cnt_q;
    base     = ob_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    if (pop) begin
      ob_d[0] = ob_q[1];
      base    = ob_cnt_q - 2'd1;
    end
    ob_cnt_d = base;

    // The read issued last edge lands behind whatever survives the pop.
    if (rif_q) begin
      if (base == 2'd0) ob_d[0] = ram_doutb;
      else              ob_d[1] = ram_doutb;
      ob_cnt_d = base + 2'd1;
    end
  end

  // State registers with synchronous active-low reset; RAM contents are abandoned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rif_q    <= 1'b0;
      ob_cnt_q <= 2'd0;
      ob_q[0]  <= '0;
      ob_q[1]  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rif_q    <= rif_d;
      ob_cnt_q <= ob_cnt_d;
      ob_q[0]  <= ob_d[0];
      ob_q[1]  <= ob_d[1];
    end
  end

endmodule

// File: tb/tb_dp_be_ram_fifo_ctrl.sv
// Bench for dp_be_ram_fifo_ctrl with a behavioural dual-port byte-enable RAM.
// Directed vector table first, then fill, streaming, random backpressure and mid-stream reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dp_be_ram_fifo_ctrl;
  localparam int W  = 256;
  localparam int D  = 64;
  localparam int AW = $clog2(D);
  localparam int BW = W / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready, m_valid, m_ready;
  logic [W-1:0]  s_data, m_data;
  logic [AW+1:0] count;
  logic          empty, full;
  logic          ram_ena, ram_enb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [BW-1:0] ram_wea, ram_web;
  logic [W-1:0]  ram_dina, ram_dinb, ram_doutb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dp_be_ram_fifo_ctrl #(.W(W), .D(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .empty(empty), .full(full),
    .ram_ena(ram_ena), .ram_addra(ram_addra), .ram_wea(ram_wea), .ram_dina(ram_dina),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_web(ram_web), .ram_dinb(ram_dinb),
    .ram_doutb(ram_doutb)
  );

  // RAM model: byte-enabled write on port A, registered read on port B.
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (ram_ena)
      for (int b = 0; b < BW; b++)
        if (ram_wea[b]) mem[ram_addra][b*8 +: 8] <= ram_dina[b*8 +: 8];
    if (ram_enb) ram_doutb <= mem[ram_addrb];
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, sv, mr;
    logic [15:0] dat;
    logic        e_srdy, e_ena, e_enb, e_mv, chk_md;
    logic [15:0] e_md;
    logic [7:0]  e_cnt;
    logic        e_empty;
    logic [5:0]  e_addra, e_addrb;
  } vec_t;

  function automatic vec_t mk(logic rst, logic sv, logic mr, logic [15:0] dat,
                              logic srdy, logic ena, logic [5:0] aa, logic enb, logic [5:0] ab,
                              logic mv, logic cmd, logic [15:0] md, logic [7:0] cnt, logic emp);
    vec_t v;
    v.rst = rst; v.sv = sv; v.mr = mr; v.dat = dat;
    v.e_srdy = srdy; v.e_ena = ena; v.e_addra = aa; v.e_enb = enb; v.e_addrb = ab;
    v.e_mv = mv; v.chk_md = cmd; v.e_md = md; v.e_cnt = cnt; v.e_empty = emp;
    return v;
  endfunction

  // Scoreboard shared by the multi-cycle sequences.
  logic [W-1:0] sb [$];
  logic         hold = 1'b0;
  logic [W-1:0] prev_md = '0;

  task automatic cycle(input logic rst, input logic sv, input logic mr, input logic [W-1:0] d);
    @(negedge clk);
    rst_n = rst; s_valid = sv; m_ready = mr; s_data = d;
    #1;
    if (!rst) begin
      sb.delete();
      hold = 1'b0;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_ram_en", {ram_ena, ram_enb}, 0);
    end else begin
      if (hold) chk("hold_stable", m_data, prev_md);
      chk("count_max", count <= (D+2), 1);
      if (s_valid && s_ready) sb.push_back(d);
      if (m_valid && m_ready) begin
        if (sb.size() == 0) chk("pop_underflow", 1, 0);
        else chk("pop_data", m_data, sb.pop_front());
      end
      hold    = m_valid && !m_ready;
      prev_md = m_data;
    end
  endtask

  vec_t vt [$];
  int   bubbles;
  logic [W-1:0] rnd;

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    @(posedge clk);

    //        rst sv mr dat     srdy ena aa enb ab  mv cmd md      cnt emp
    vt.push_back(mk(0, 1, 1, 16'h11, 0, 0, 0, 0, 0, 0, 1, 16'h0, 0, 1));
    vt.push_back(mk(0, 1, 1, 16'h11, 0, 0, 0, 0, 0, 0, 1, 16'h0, 0, 1));
    vt.push_back(mk(0, 1, 1, 16'h11, 0, 0, 0, 0, 0, 0, 1, 16'h0, 0, 1));
    vt.push_back(mk(1, 1, 0, 16'hA5, 1, 1, 0, 0, 0, 0, 1, 16'h0, 0, 1));
    vt.push_back(mk(1, 0, 0, 16'h0,  1, 0, 0, 1, 0, 0, 0, 16'h0, 1, 0));
    vt.push_back(mk(1, 0, 0, 16'h0,  1, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0));
    vt.push_back(mk(1, 0, 1, 16'h0,  1, 0, 0, 0, 0, 1, 1, 16'hA5, 1, 0));
    vt.push_back(mk(1, 1, 1, 16'h1,  1, 1, 1, 0, 0, 0, 0, 16'h0, 0, 1));
    vt.push_back(mk(1, 1, 1, 16'h2,  1, 1, 2, 1, 1, 0, 0, 16'h0, 1, 0));
    vt.push_back(mk(1, 1, 1, 16'h3,  1, 1, 3, 1, 2, 0, 0, 16'h0, 2, 0));
    vt.push_back(mk(1, 0, 1, 16'h0,  1, 0, 0, 1, 3, 1, 1, 16'h1, 3, 0));
    vt.push_back(mk(1, 0, 1, 16'h0,  1, 0, 0, 0, 0, 1, 1, 16'h2, 2, 0));
    vt.push_back(mk(1, 0, 0, 16'h0,  1, 0, 0, 0, 0, 1, 1, 16'h3, 1, 0));
    vt.push_back(mk(1, 0, 0, 16'h0,  1, 0, 0, 0, 0, 1, 1, 16'h3, 1, 0));
    vt.push_back(mk(1, 0, 1, 16'h0,  1, 0, 0, 0, 0, 1, 1, 16'h3, 1, 0));
    vt.push_back(mk(1, 0, 0, 16'h0,  1, 0, 0, 0, 0, 0, 0, 16'h0, 0, 1));

    foreach (vt[i]) begin
      @(negedge clk);
      rst_n = vt[i].rst; s_valid = vt[i].sv; m_ready = vt[i].mr; s_data = W'(vt[i].dat);
      #1;
      chk($sformatf("v%0d_s_ready", i), s_ready, vt[i].e_srdy);
      chk($sformatf("v%0d_ram_ena", i), ram_ena, vt[i].e_ena);
      chk($sformatf("v%0d_ram_wea", i), ram_wea, vt[i].e_ena ? {BW{1'b1}} : {BW{1'b0}});
      chk($sformatf("v%0d_ram_enb", i), ram_enb, vt[i].e_enb);
      chk($sformatf("v%0d_m_valid", i), m_valid, vt[i].e_mv);
      chk($sformatf("v%0d_count", i), count, vt[i].e_cnt);
      chk($sformatf("v%0d_empty", i), empty, vt[i].e_empty);
      chk($sformatf("v%0d_full", i), full, 0);
      chk($sformatf("v%0d_port_b_wr", i), {ram_web, ram_dinb}, 0);
      if (vt[i].chk_md) chk($sformatf("v%0d_m_data", i), m_data, W'(vt[i].e_md));
      if (vt[i].e_ena)  chk($sformatf("v%0d_addra", i), ram_addra, vt[i].e_addra);
      if (vt[i].e_enb)  chk($sformatf("v%0d_addrb", i), ram_addrb, vt[i].e_addrb);
    end

    // Fill to D+2 with the sink stalled, try one extra push, then drain in order.
    for (int i = 0; i < D + 2; i++) begin
      cycle(1, 1, 0, W'(i));
      chk("fill_accept", s_ready, 1);
    end
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0);
    chk("fill_count", count, D + 2);
    chk("fill_full", full, 1);
    chk("fill_s_ready", s_ready, 0);
    cycle(1, 1, 0, W'(16'hDEAD));
    chk("extra_push_ena", ram_ena, 0);
    cycle(1, 0, 0, '0);
    chk("extra_push_count", count, D + 2);
    for (int i = 0; i < D + 2; i++) begin
      cycle(1, 0, 1, '0);
      chk("drain_valid", m_valid, 1);
    end
    cycle(1, 0, 0, '0);
    chk("drain_empty", empty, 1);
    chk("drain_sb", sb.size(), 0);

    // Streaming: one push and one pop per cycle, no bubbles after the 2-cycle latency.
    bubbles = 0;
    for (int k = 0; k < 1000; k++) begin
      cycle(1, 1, 1, W'(k + 100));
      if (k >= 3 && !m_valid) bubbles++;
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 1, '0);
      if (!m_valid) bubbles++;
    end
    chk("stream_bubbles", bubbles, 0);
    cycle(1, 0, 0, '0);
    chk("stream_empty", empty, 1);
    chk("stream_sb", sb.size(), 0);

    // Random 50% valid/ready traffic against the scoreboard.
    for (int k = 0; k < 5000; k++) begin
      for (int j = 0; j < W / 32; j++) rnd[j*32 +: 32] = $urandom();
      cycle(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd);
    end
    for (int k = 0; k < 200; k++) cycle(1, 0, 1, '0);
    chk("rand_empty", empty, 1);
    chk("rand_sb", sb.size(), 0);

    // Mid-stream reset with count=10 and a read in flight.
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, W'(200 + i));
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0);
    cycle(1, 1, 1, W'(300));
    cycle(0, 1, 1, W'(16'h55));
    chk("pre_rst_count", count, 10);
    cycle(1, 0, 0, '0);
    chk("post_rst_count", count, 0);
    chk("post_rst_m_valid", m_valid, 0);
    chk("post_rst_s_ready", s_ready, 1);
    cycle(1, 1, 0, W'(16'h3C));
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0);
    chk("post_rst_head", m_data, W'(16'h3C));
    chk("post_rst_count1", count, 1);
    cycle(1, 0, 1, '0);
    cycle(1, 0, 0, '0);
    chk("post_rst_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
